// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: window tap indices,
// default frame geometry and a tap extraction helper.
package img_pkg;

  localparam int IMG_W_DEF = 176;
  localparam int IMG_H_DEF = 176;
  localparam int PIX_W     = 8;

  localparam int A0 = 0;
  localparam int A1 = 1;
  localparam int A2 = 2;
  localparam int B0 = 3;
  localparam int B1 = 4;
  localparam int B2 = 5;
  localparam int C0 = 6;
  localparam int C1 = 7;
  localparam int C2 = 8;

  function automatic logic [PIX_W-1:0] win_tap(
    input logic [9*PIX_W-1:0] win,
    input int                 idx
  );
    return win[idx*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/line_ram.sv
// One image line of storage, single address, combinational
// read so the old word is seen on the same edge it is overwritten.
module line_ram #(
  parameter int DEPTH = 176,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          pclk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // write port; contents are deliberately not reset
  always_ff @(posedge pclk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/line_window_3x3.sv
// Streaming 3x3 neighbourhood generator with address-counted
// line buffers; emits interior windows with centre coordinates.
module line_window_3x3
  import img_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_W,
  parameter int IMG_WIDTH  = IMG_W_DEF,
  parameter int IMG_HEIGHT = IMG_H_DEF,
  localparam int CW = $clog2(IMG_WIDTH),
  localparam int RW = $clog2(IMG_HEIGHT),
  localparam int DW = DATA_WIDTH
) (
  input  logic            pclk,
  input  logic            reset,
  input  logic            sof,
  input  logic            pix_in_valid,
  input  logic [DW-1:0]   pix_in,
  output logic            win_valid,
  output logic [9*DW-1:0] win_out,
  output logic [RW-1:0]   win_row,
  output logic [CW-1:0]   win_col,
  output logic            frame_done
);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] pos_col;
  logic [RW-1:0] pos_row;
  logic          col_last;
  logic          row_last;
  logic [DW-1:0] lb1_q;
  logic [DW-1:0] lb0_q;

  // sof re-anchors the accepted pixel at the frame origin
  assign pos_col  = sof ? '0 : col;
  assign pos_row  = sof ? '0 : row;
  assign col_last = pos_col == CW'(IMG_WIDTH - 1);
  assign row_last = pos_row == RW'(IMG_HEIGHT - 1);

  line_ram #(
    .DEPTH (IMG_WIDTH),
    .DW    (DW)
  ) u_lb1 (
    .pclk  (pclk),
    .we    (pix_in_valid),
    .addr  (pos_col),
    .wdata (pix_in),
    .rdata (lb1_q)
  );

  line_ram #(
    .DEPTH (IMG_WIDTH),
    .DW    (DW)
  ) u_lb0 (
    .pclk  (pclk),
    .we    (pix_in_valid),
    .addr  (pos_col),
    .wdata (lb1_q),
    .rdata (lb0_q)
  );

  // raster position of the next accepted pixel
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (pix_in_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : pos_row + RW'(1);
      end else begin
        col <= pos_col + CW'(1);
        row <= pos_row;
      end
    end
  end

  // shift each window row left by one column, newest in x0
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      win_out <= '0;
    end else if (pix_in_valid) begin
      win_out <= {win_out[6*DW +: 2*DW], pix_in,
                  win_out[3*DW +: 2*DW], lb1_q,
                  win_out[0    +: 2*DW], lb0_q};
    end
  end

  // centre coordinates follow the window; hold when idle
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      win_row <= '0;
      win_col <= '0;
    end else if (pix_in_valid) begin
      win_row <= pos_row - RW'(1);
      win_col <= pos_col - CW'(1);
    end
  end

  // qualifiers: interior window and end-of-frame pulse
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= pix_in_valid
                 && pos_row >= RW'(2)
                 && pos_col >= CW'(2);
      frame_done <= pix_in_valid && row_last && col_last;
    end
  end

endmodule

// File: tb/tb_line_window_3x3.sv
// Scoreboard bench for line_window_3x3 on an 8x8 frame:
// driver queues expected windows, negedge monitor compares.
module tb_line_window_3x3;
  import img_pkg::*;

  localparam int W = 8;
  localparam int H = 8;

  logic        pclk = 1'b0;
  logic        reset = 1'b0;
  logic        sof = 1'b0;
  logic        pix_in_valid = 1'b0;
  logic [7:0]  pix_in = '0;
  logic        win_valid;
  logic [71:0] win_out;
  logic [2:0]  win_row;
  logic [2:0]  win_col;
  logic        frame_done;

  line_window_3x3 #(
    .DATA_WIDTH (8),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .pclk         (pclk),
    .reset        (reset),
    .sof          (sof),
    .pix_in_valid (pix_in_valid),
    .pix_in       (pix_in),
    .win_valid    (win_valid),
    .win_out      (win_out),
    .win_row      (win_row),
    .win_col      (win_col),
    .frame_done   (frame_done)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic        v;
    logic        fd;
    logic        ramp;
    logic [2:0]  r;
    logic [2:0]  c;
    logic [71:0] w;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   nvalid = 0;
  int   nfd = 0;
  int   mode = 0;
  logic acc_d = 1'b0;

  function automatic logic [7:0] pv(input int m, input int r, input int c);
    case (m)
      0:       return 8'(8*r + c);
      1:       return 8'(16*r + c);
      default: return 8'(8*r + c + 100);
    endcase
  endfunction

  function automatic logic [71:0] exp_win(input int m, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 3; k++) begin
      w[k*8 +: 8]     = pv(m, r-2, c-k);
      w[(k+3)*8 +: 8] = pv(m, r-1, c-k);
      w[(k+6)*8 +: 8] = pv(m, r,   c-k);
    end
    return w;
  endfunction

  task automatic chk(input string n, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(posedge pclk or negedge reset) begin
    if (!reset) acc_d <= 1'b0;
    else        acc_d <= pix_in_valid;
  end

  always @(negedge pclk) begin
    exp_t e;
    if (reset) begin
      if (win_valid)  nvalid++;
      if (frame_done) nfd++;
      if (!acc_d) begin
        chk("idle_valid", 72'(win_valid), 72'(0));
        chk("idle_fdone", 72'(frame_done), 72'(0));
      end else if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: accept seen with no expected entry");
      end else begin
        e = q.pop_front();
        chk("valid", 72'(win_valid), 72'(e.v));
        chk("fdone", 72'(frame_done), 72'(e.fd));
        if (e.v) begin
          chk("window", win_out, e.w);
          chk("row", 72'(win_row), 72'(e.r));
          chk("col", 72'(win_col), 72'(e.c));
          if (e.ramp && e.r == 3'd1 && e.c == 3'd1)
            chk("win_1_1", win_out,
                {8'd16, 8'd17, 8'd18, 8'd8, 8'd9, 8'd10,
                 8'd0, 8'd1, 8'd2});
          if (e.ramp && e.r == 3'd6 && e.c == 3'd6) begin
            chk("a0_6_6", 72'(win_tap(win_out, A0)), 72'(47));
            chk("c2_6_6", 72'(win_tap(win_out, C2)), 72'(61));
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic px(input int r, input int c, input bit s);
    exp_t e;
    e = '0;
    e.v    = (r >= 2 && c >= 2);
    e.fd   = (r == H-1 && c == W-1);
    e.ramp = (mode == 0);
    e.r    = 3'(r - 1);
    e.c    = 3'(c - 1);
    if (e.v) e.w = exp_win(mode, r, c);
    q.push_back(e);
    sof          = s;
    pix_in_valid = 1'b1;
    pix_in       = pv(mode, r, c);
    @(posedge pclk);
    #1;
    sof          = 1'b0;
    pix_in_valid = 1'b0;
  endtask

  task automatic frame(input bit s0, input bit bub);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (bub && $urandom_range(0, 1) == 1) idle(1);
        px(r, c, s0 && r == 0 && c == 0);
      end
  endtask

  task automatic chk_reset_outs(input string n);
    chk({n, "_win"}, win_out, 72'(0));
    chk({n, "_valid"}, 72'(win_valid), 72'(0));
    chk({n, "_row"}, 72'(win_row), 72'(0));
    chk({n, "_col"}, 72'(win_col), 72'(0));
    chk({n, "_fd"}, 72'(frame_done), 72'(0));
  endtask

  initial begin
    repeat (2) @(posedge pclk);
    #1;
    chk_reset_outs("por");
    reset = 1'b1;
    idle(1);

    mode = 0; nvalid = 0; nfd = 0;
    frame(1'b1, 1'b0);
    idle(3);
    chk("ramp_count", 72'(nvalid), 72'(36));
    chk("ramp_fd", 72'(nfd), 72'(1));

    nvalid = 0; nfd = 0;
    frame(1'b1, 1'b1);
    idle(3);
    chk("bubble_count", 72'(nvalid), 72'(36));
    chk("bubble_fd", 72'(nfd), 72'(1));

    mode = 2; nvalid = 0; nfd = 0;
    for (int i = 0; i < 4*W + 3; i++) px(i / W, i % W, i == 0);
    frame(1'b1, 1'b0);
    idle(3);
    chk("midsof_count", 72'(nvalid), 72'(49));
    chk("midsof_fd", 72'(nfd), 72'(1));

    mode = 0; nvalid = 0; nfd = 0;
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
    idle(3);
    chk("b2b_count", 72'(nvalid), 72'(72));
    chk("b2b_fd", 72'(nfd), 72'(2));

    mode = 1;
    for (int i = 0; i < 5*W + 5; i++) px(i / W, i % W, i == 0);
    @(negedge pclk);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outs("midrst");
    chk("midrst_sb", 72'(q.size()), 72'(0));
    @(posedge pclk);
    #1;
    reset = 1'b1;
    nvalid = 0; nfd = 0;
    frame(1'b0, 1'b0);
    idle(3);
    chk("rst_count", 72'(nvalid), 72'(36));
    chk("rst_fd", 72'(nfd), 72'(1));

    chk("sb_drain", 72'(q.size()), 72'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
